// File: rtl/wdt_pkg.sv
// Shared register offsets, bus widths and FSM state type for the watchdog timer.
package wdt_pkg;

    localparam int WDT_ADDR_W = 16;
    localparam int WDT_DATA_W = 32;

    localparam logic [WDT_ADDR_W-1:0] WDT_WDEN_OFF   = 16'h0100;
    localparam logic [WDT_ADDR_W-1:0] WDT_WDLIVE_OFF = 16'h0200;
    localparam logic [WDT_ADDR_W-1:0] WDT_WTOCNT_OFF = 16'h0300;

    typedef enum logic [1:0] {
        WDT_IDLE,
        WDT_COUNT,
        WDT_EXPIRED
    } wdt_state_e;

    // True when a bus write targets the given register offset.
    function automatic logic wdt_hit(input logic                  en,
                                     input logic [WDT_ADDR_W-1:0] addr,
                                     input logic [WDT_ADDR_W-1:0] off);
        return en && (addr == off);
    endfunction

endpackage

// File: rtl/wdt_timer_if.sv
// Register access bus of the watchdog: single-cycle write strobe and
// read strobe with registered read data.
interface wdt_timer_if;
    import wdt_pkg::*;

    logic                  wr_en;
    logic [WDT_ADDR_W-1:0] wr_addr;
    logic [WDT_DATA_W-1:0] wr_data;
    logic                  rd_en;
    logic [WDT_ADDR_W-1:0] rd_addr;
    logic [WDT_DATA_W-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );

endinterface

// File: rtl/wdt_prescaler.sv
// Divides clk down to one counter tick every PRESCALE cycles while enabled.
// clr has priority and returns the phase to zero; with en low the phase holds.
module wdt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    assign tick = en && (presc == LAST);

    // Phase counter: clear, wrap on tick, otherwise advance while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

endmodule

// File: rtl/wdt_timer.sv
// Watchdog timer slave: WDEN/WDLIVE/WTOCNT registers, prescaled counter and
// the IDLE/COUNT/EXPIRED state machine driving the timeout level.
// CNT_W must not exceed the 32-bit data bus width.
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    wdt_timer_if.slave bus,
    output logic       timeout
);

    wdt_state_e            state;
    wdt_state_e            state_nx;
    logic                  wden;
    logic [CNT_W-1:0]      wtocnt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nx;
    logic                  tick;
    logic                  presc_en;
    logic                  presc_clr;
    logic                  wr_wden;
    logic                  wr_wtocnt;
    logic                  kick;
    logic                  enable_wr;
    logic                  disable_wr;
    logic [WDT_DATA_W-1:0] rd_mux;

    assign wr_wden    = wdt_hit(bus.wr_en, bus.wr_addr, WDT_WDEN_OFF);
    assign wr_wtocnt  = wdt_hit(bus.wr_en, bus.wr_addr, WDT_WTOCNT_OFF);
    assign kick       = wdt_hit(bus.wr_en, bus.wr_addr, WDT_WDLIVE_OFF) && bus.wr_data[0];
    assign enable_wr  = wr_wden && bus.wr_data[0];
    assign disable_wr = wr_wden && !bus.wr_data[0];

    // The prescaler only runs while counting, so its phase is frozen in EXPIRED.
    assign presc_en = (state == WDT_COUNT);

    wdt_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Software-visible registers: enable bit and timeout threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wden   <= 1'b0;
            wtocnt <= '0;
        end else begin
            if (wr_wden) begin
                wden <= bus.wr_data[0];
            end
            if (wr_wtocnt) begin
                wtocnt <= bus.wr_data[CNT_W-1:0];
            end
        end
    end

    // Read data selection; unmapped offsets and WDLIVE read as zero.
    always_comb begin
        rd_mux = '0;
        case (bus.rd_addr)
            WDT_WDEN_OFF:   rd_mux[0]         = wden;
            WDT_WTOCNT_OFF: rd_mux[CNT_W-1:0] = wtocnt;
            default:        rd_mux            = '0;
        endcase
    end

    // Registered read port, holding its value between read strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_data <= '0;
        end else if (bus.rd_en) begin
            bus.rd_data <= rd_mux;
        end
    end

    // State, counter and timeout registers.
    // timeout is loaded from the next state so it changes on the same edge
    // as the state and also falls asynchronously with reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WDT_IDLE;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            timeout <= (state_nx == WDT_EXPIRED);
        end
    end

    // Next-state logic: disable and kick take priority over a coincident expiry.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        presc_clr = 1'b0;
        case (state)
            WDT_IDLE: begin
                cnt_nx    = '0;
                presc_clr = 1'b1;
                if (enable_wr) begin
                    state_nx = WDT_COUNT;
                end
            end
            WDT_COUNT: begin
                if (disable_wr) begin
                    state_nx  = WDT_IDLE;
                    cnt_nx    = '0;
                    presc_clr = 1'b1;
                end else if (kick) begin
                    cnt_nx    = '0;
                    presc_clr = 1'b1;
                end else if (tick) begin
                    if (cnt >= wtocnt) begin
                        state_nx = WDT_EXPIRED;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            WDT_EXPIRED: begin
                if (disable_wr) begin
                    state_nx  = WDT_IDLE;
                    cnt_nx    = '0;
                    presc_clr = 1'b1;
                end else if (kick) begin
                    state_nx  = WDT_COUNT;
                    cnt_nx    = '0;
                    presc_clr = 1'b1;
                end
            end
            default: begin
                state_nx  = WDT_IDLE;
                cnt_nx    = '0;
                presc_clr = 1'b1;
            end
        endcase
    end

endmodule
